// File: rtl/ioctl_sdram_loader_pkg.sv
// Shared encodings for the ioctl -> SDRAM loader.
// Latency: none (types and constants only).
// Backpressure: n/a.
package ioctl_sdram_loader_pkg;

  // Control FSM: tracks the download session
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    SKIP  = 2'd3
  } ctl_state_t;

  // Memory FSM: one outstanding toggle req/ack write at a time
  typedef enum logic {
    MIDLE = 1'b0,
    MWAIT = 1'b1
  } mem_state_t;

  // Byte enables {hi,lo}
  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

endpackage

// File: rtl/ioctl_sdram_loader_if.sv
// ioctl byte stream plus SDRAM toggle req/ack write port.
// Latency: none (wiring only).
// Backpressure: clkref_n paces the byte stream; mem_ack paces the writes.
interface ioctl_sdram_loader_if #(
  parameter int ADDR_W = 24
) ();
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              clkref_n;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [1:0]        mem_ds;

  // The loader: consumes bytes, drives the memory write port
  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output clkref_n, mem_req, mem_addr, mem_din, mem_ds
  );

  // The environment: download path and SDRAM controller
  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  clkref_n, mem_req, mem_addr, mem_din, mem_ds
  );
endinterface

// File: rtl/ioctl_sdram_loader_word_fifo.sv
// Synchronous word FIFO holding {word addr, data, byte enables}.
// Latency: pushed word visible at the head the cycle after push.
// Backpressure: push while full is dropped; producer must respect count.
module ioctl_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 42
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ioctl_sdram_loader.sv
// Packs ioctl bytes into 16-bit LE words and writes them to SDRAM via toggle req/ack.
// Latency: FIFO push to mem_req toggle is 1 cycle.
// Backpressure: clkref_n strobes only while the FIFO has room for a worst-case byte (2 words).
module ioctl_sdram_loader
  import ioctl_sdram_loader_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_WADDR = '0,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [5:0]        INDEX_SEL  = 6'd0
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  ioctl_sdram_loader_if.master bus,
  output logic                busy,
  output logic                load_done,
  output logic [ADDR_W-1:0]   word_count
);
  localparam int FW    = ADDR_W + 18;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CLK_LIM = CNT_W'(FIFO_DEPTH - 3);

  ctl_state_t        state, state_nxt;
  mem_state_t        mstate, mstate_nxt;
  logic              hold_vld, odd_pend;
  logic [7:0]        hold_byte, odd_byte;
  logic [ADDR_W-1:0] hold_waddr, odd_waddr, in_waddr;
  logic              in_odd, byte_wr, odd_match, index_hit, flush_done;
  logic              push, pop, fifo_empty, fifo_full, clkref_nxt;
  logic [FW-1:0]     push_dat, fifo_head;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              unused_index_hi;

  assign unused_index_hi = &{1'b0, bus.ioctl_index[7:6]};
  assign in_waddr  = BASE_WADDR + ADDR_W'(bus.ioctl_addr[24:1]);
  assign in_odd    = bus.ioctl_addr[0];
  assign byte_wr   = bus.ioctl_wr && (state == LOAD);
  assign odd_match = hold_vld && (hold_waddr == in_waddr);
  assign index_hit = (bus.ioctl_index[5:0] == INDEX_SEL);
  assign busy      = (state == LOAD) || (state == FLUSH);
  assign flush_done = (state == FLUSH) && !hold_vld && !odd_pend && fifo_empty && (mstate == MIDLE);

  // Control next state; IDLE starts on download level so a start seen during FLUSH is taken once drained
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.ioctl_download) state_nxt = index_hit ? LOAD : SKIP;
      LOAD:    if (!bus.ioctl_download) state_nxt = FLUSH;
      FLUSH:   if (flush_done) state_nxt = IDLE;
      SKIP:    if (!bus.ioctl_download) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Packer push selection: deferred odd byte wins, then pairing/eviction, then flush of the hold byte
  always_comb begin
    push     = 1'b0;
    push_dat = '0;
    if (odd_pend) begin
      push     = 1'b1;
      push_dat = {odd_waddr, odd_byte, 8'h00, DS_HI};
    end else if (byte_wr) begin
      if (in_odd && odd_match) begin
        push     = 1'b1;
        push_dat = {in_waddr, bus.ioctl_dout, hold_byte, DS_BOTH};
      end else if (hold_vld) begin
        push     = 1'b1;
        push_dat = {hold_waddr, 8'h00, hold_byte, DS_LO};
      end
    end else if ((state == FLUSH) && hold_vld) begin
      push     = 1'b1;
      push_dat = {hold_waddr, 8'h00, hold_byte, DS_LO};
    end
  end

  // Hold register and deferred odd byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld   <= 1'b0;
      hold_byte  <= '0;
      hold_waddr <= '0;
      odd_pend   <= 1'b0;
      odd_byte   <= '0;
      odd_waddr  <= '0;
    end else begin
      odd_pend <= 1'b0;
      if (byte_wr && !odd_pend) begin
        if (in_odd) begin
          hold_vld <= 1'b0;
          if (!odd_match) begin
            odd_pend  <= 1'b1;
            odd_byte  <= bus.ioctl_dout;
            odd_waddr <= in_waddr;
          end
        end else begin
          hold_vld   <= 1'b1;
          hold_byte  <= bus.ioctl_dout;
          hold_waddr <= in_waddr;
        end
      end else if ((state == FLUSH) && !odd_pend) begin
        hold_vld <= 1'b0;
      end
    end
  end

  ioctl_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .count    (fifo_cnt),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Strobe only when no byte or deferred push is in flight, so count already reflects the last byte
  always_comb begin
    clkref_nxt = 1'b1;
    if (bus.clkref_n && !bus.ioctl_wr && !odd_pend && bus.ioctl_download) begin
      if (state == SKIP)
        clkref_nxt = 1'b0;
      else if ((state == LOAD) && (fifo_cnt <= CLK_LIM) && !fifo_full)
        clkref_nxt = 1'b0;
    end
  end

  // Memory next state; ack only matters while a request is outstanding
  always_comb begin
    mstate_nxt = mstate;
    pop        = 1'b0;
    case (mstate)
      MIDLE:   if (!fifo_empty) mstate_nxt = MWAIT;
      MWAIT:   if (bus.mem_ack == bus.mem_req) begin
                 pop        = 1'b1;
                 mstate_nxt = MIDLE;
               end
      default: mstate_nxt = MIDLE;
    endcase
  end

  // Memory state, write port registers, flow-control strobe and status
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mstate       <= MIDLE;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.mem_ds   <= '0;
      bus.clkref_n <= 1'b1;
      word_count   <= '0;
      load_done    <= 1'b0;
    end else begin
      mstate       <= mstate_nxt;
      bus.clkref_n <= clkref_nxt;
      load_done    <= flush_done;
      if ((mstate == MIDLE) && !fifo_empty) begin
        {bus.mem_addr, bus.mem_din, bus.mem_ds} <= fifo_head;
        bus.mem_req <= ~bus.mem_req;
      end
      if ((state == IDLE) && (state_nxt == LOAD)) word_count <= '0;
      else if (pop)                               word_count <= word_count + ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench: byte driver obeying clkref_n, SDRAM responder with programmable ack delay.
module tb_ioctl_sdram_loader;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy;
  logic        load_done;
  logic [23:0] word_count;

  int checks = 0;
  int errors = 0;
  int ack_delay = 1;
  int done_cnt = 0;
  int busy_hi = 0;
  int full_seen = 0;
  int stall_viol = 0;

  logic [23:0] log_addr[$];
  logic [15:0] log_din[$];
  logic [1:0]  log_ds[$];
  bit          log_fl[$];

  always #5 clk_sys = ~clk_sys;

  ioctl_sdram_loader_if #(.ADDR_W(24)) bus ();

  ioctl_sdram_loader #(
    .ADDR_W(24), .BASE_WADDR(24'd0), .FIFO_DEPTH(8), .INDEX_SEL(6'd0)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .load_done  (load_done),
    .word_count (word_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int i, input logic [23:0] a,
                          input logic [15:0] d, input logic [1:0] s);
    if (i < log_addr.size()) begin
      check({tag, "_addr"}, 32'(log_addr[i]), 32'(a));
      check({tag, "_din"},  32'(log_din[i]),  32'(d));
      check({tag, "_ds"},   32'(log_ds[i]),   32'(s));
    end else begin
      check({tag, "_missing"}, 32'(log_addr.size()), 32'(i + 1));
    end
  endtask

  // SDRAM controller model: logs each new request, acks after ack_delay cycles
  initial begin
    logic last_req;
    int   wait_cnt;
    bus.mem_ack = 1'b0;
    last_req = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        bus.mem_ack = 1'b0;
        last_req = 1'b0;
      end else if (bus.mem_req !== last_req) begin
        last_req = bus.mem_req;
        wait_cnt = ack_delay;
        log_addr.push_back(bus.mem_addr);
        log_din.push_back(bus.mem_din);
        log_ds.push_back(bus.mem_ds);
        log_fl.push_back(busy && !bus.ioctl_download);
      end else if (bus.mem_ack !== bus.mem_req) begin
        if (wait_cnt > 1) wait_cnt--;
        else bus.mem_ack = bus.mem_req;
      end
    end
  end

  // Status monitor
  initial begin
    forever begin
      @(negedge clk_sys);
      if (load_done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_hi++;
      if (dut.fifo_full === 1'b1) full_seen++;
      if (busy === 1'b1 && bus.clkref_n === 1'b0 && dut.fifo_cnt >= 4'd6) stall_viol++;
    end
  end

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b0;
  endtask

  // Download path: write the cycle after a clkref_n strobe; optionally drop download with it
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit last);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (bus.clkref_n !== 1'b0 && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    if (bus.clkref_n !== 1'b0) begin
      check("clkref_wait", 32'(bus.clkref_n), 32'd0);
    end else begin
      @(posedge clk_sys); #1;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      if (last) bus.ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      bus.ioctl_wr = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int n = 0; n < budget && busy !== 1'b0; n++) @(negedge clk_sys);
    repeat (2) @(negedge clk_sys);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk_sys);
      if (bus.clkref_n === 1'b0) lows++;
    end
  endtask

  initial begin
    int lb, db, bb, lows;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_clkref_n", 32'(bus.clkref_n), 32'd1);
    check("rst_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_din",  32'(bus.mem_din),  32'd0);
    check("rst_mem_ds",   32'(bus.mem_ds),   32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_load_done", 32'(load_done),   32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    reset_n = 1'b1;

    // Test 1: four bytes, full words, ack after 1 cycle
    ack_delay = 1;
    lb = log_addr.size(); db = done_cnt;
    start_dl(8'h00);
    send_byte(25'd0, 8'h11, 1'b0);
    send_byte(25'd1, 8'h22, 1'b0);
    send_byte(25'd2, 8'h33, 1'b0);
    send_byte(25'd3, 8'h44, 1'b0);
    end_dl();
    wait_idle("t1_idle", 300);
    check("t1_nwr", 32'(log_addr.size() - lb), 32'd2);
    check_wr("t1_w0", lb,     24'd0, 16'h2211, 2'b11);
    check_wr("t1_w1", lb + 1, 24'd1, 16'h4433, 2'b11);
    check("t1_word_count", 32'(word_count), 32'd2);
    check("t1_load_done", 32'(done_cnt - db), 32'd1);

    // Test 2: odd length, download falls with the last byte; tail word issued in FLUSH
    lb = log_addr.size(); db = done_cnt;
    start_dl(8'h00);
    send_byte(25'd0, 8'h55, 1'b0);
    send_byte(25'd1, 8'h66, 1'b0);
    send_byte(25'd2, 8'h77, 1'b1);
    wait_idle("t2_idle", 300);
    check("t2_nwr", 32'(log_addr.size() - lb), 32'd2);
    check_wr("t2_w0", lb,     24'd0, 16'h6655, 2'b11);
    check_wr("t2_w1", lb + 1, 24'd1, 16'h0077, 2'b01);
    if (lb + 1 < log_fl.size()) check("t2_in_flush", 32'(log_fl[lb + 1]), 32'd1);
    check("t2_word_count", 32'(word_count), 32'd2);
    check("t2_load_done", 32'(done_cnt - db), 32'd1);

    // Test 3: address jump splits into lo/hi halves; top of the byte space
    lb = log_addr.size();
    start_dl(8'h00);
    send_byte(25'd4, 8'hA1, 1'b0);
    send_byte(25'd9, 8'hB2, 1'b0);
    send_byte(25'h1FFFFFE, 8'hCC, 1'b0);
    send_byte(25'h1FFFFFF, 8'hDD, 1'b0);
    end_dl();
    wait_idle("t3_idle", 300);
    check("t3_nwr", 32'(log_addr.size() - lb), 32'd3);
    check_wr("t3_w0", lb,     24'd2,       16'h00A1, 2'b01);
    check_wr("t3_w1", lb + 1, 24'd4,       16'hB200, 2'b10);
    check_wr("t3_w2", lb + 2, 24'hFFFFFF,  16'hDDCC, 2'b11);
    check("t3_word_count", 32'(word_count), 32'd3);

    // Test 4: slow SDRAM; loader must stall the download path without losing bytes
    ack_delay = 50;
    lb = log_addr.size();
    start_dl(8'h00);
    for (int i = 0; i < 12; i++) send_byte(25'(256 + i), 8'(16 + i), 1'b0);
    count_lows(10, lows);
    check("t4_stalled", 32'(lows), 32'd0);
    for (int i = 12; i < 16; i++) send_byte(25'(256 + i), 8'(16 + i), 1'b0);
    end_dl();
    wait_idle("t4_idle", 1500);
    check("t4_nwr", 32'(log_addr.size() - lb), 32'd8);
    for (int k = 0; k < 8; k++)
      check_wr($sformatf("t4_w%0d", k), lb + k, 24'(128 + k),
               16'(((17 + 2 * k) << 8) | (16 + 2 * k)), 2'b11);
    check("t4_word_count", 32'(word_count), 32'd8);
    check("t4_fifo_full", 32'(full_seen), 32'd0);
    check("t4_strobe_at_margin", 32'(stall_viol), 32'd0);

    // Test 5: index mismatch is consumed but never stored
    lb = log_addr.size(); db = done_cnt; bb = busy_hi;
    start_dl(8'h05);
    count_lows(10, lows);
    check("t5_skip_strobes", 32'(lows > 0), 32'd1);
    send_byte(25'd0, 8'hEE, 1'b0);
    send_byte(25'd1, 8'hEF, 1'b0);
    end_dl();
    repeat (10) @(negedge clk_sys);
    check("t5_no_req", 32'(log_addr.size() - lb), 32'd0);
    check("t5_no_busy", 32'(busy_hi - bb), 32'd0);
    check("t5_no_done", 32'(done_cnt - db), 32'd0);
    check("t5_word_count", 32'(word_count), 32'd8);

    // Test 6: reset mid-LOAD with three words queued, then a clean restart
    ack_delay = 50;
    start_dl(8'h00);
    for (int i = 0; i < 6; i++) send_byte(25'(64 + i), 8'(192 + i), 1'b0);
    repeat (2) @(negedge clk_sys);
    check("t6_pre_mem_addr", 32'(bus.mem_addr), 32'h20);
    check("t6_pre_queued", 32'(dut.fifo_cnt), 32'd3);
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    check("t6_clkref_n", 32'(bus.clkref_n), 32'd1);
    check("t6_mem_req",  32'(bus.mem_req),  32'd0);
    check("t6_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("t6_mem_din",  32'(bus.mem_din),  32'd0);
    check("t6_mem_ds",   32'(bus.mem_ds),   32'd0);
    check("t6_busy",     32'(busy),         32'd0);
    check("t6_word_count", 32'(word_count), 32'd0);
    check("t6_fifo_cnt", 32'(dut.fifo_cnt), 32'd0);
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    ack_delay = 1;
    repeat (2) @(negedge clk_sys);
    lb = log_addr.size(); db = done_cnt;
    start_dl(8'h00);
    repeat (2) @(negedge clk_sys);
    check("t6_restart_wc", 32'(word_count), 32'd0);
    send_byte(25'h10, 8'hC1, 1'b0);
    send_byte(25'h11, 8'hC2, 1'b0);
    end_dl();
    wait_idle("t6_idle", 300);
    check("t6_nwr", 32'(log_addr.size() - lb), 32'd1);
    check_wr("t6_w0", lb, 24'd8, 16'hC2C1, 2'b11);
    check("t6_word_count_end", 32'(word_count), 32'd1);
    check("t6_load_done", 32'(done_cnt - db), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
